// File: rtl/bpred_update_arbiter_if.sv
// Port bundle between the branch predictor arbiter and its neighbours:
// fetch lookups, execute resolutions and the single predictor table port.
interface bpred_update_arbiter_if #(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4
);
    logic                       fetch_req;
    logic [IDX_W-1:0]           fetch_idx;
    logic                       fetch_stall;
    logic                       res_valid;
    logic [IDX_W-1:0]           res_idx;
    logic                       res_taken;
    logic                       res_pred_taken;
    logic                       tbl_valid;
    logic                       tbl_we;
    logic [IDX_W-1:0]           tbl_idx;
    logic                       tbl_taken;
    logic                       flush;
    logic [$clog2(DEPTH):0]     q_count;

    modport master (
        output fetch_req, fetch_idx,
        output res_valid, res_idx, res_taken, res_pred_taken,
        input  fetch_stall, tbl_valid, tbl_we, tbl_idx, tbl_taken,
        input  flush, q_count
    );

    modport slave (
        input  fetch_req, fetch_idx,
        input  res_valid, res_idx, res_taken, res_pred_taken,
        output fetch_stall, tbl_valid, tbl_we, tbl_idx, tbl_taken,
        output flush, q_count
    );
endinterface

// File: rtl/bpred_update_arbiter.sv
// Shares the single predictor table port between fetch lookups and
// queued counter updates, and raises the misprediction flush.
module bpred_update_arbiter #(
    parameter int IDX_W      = 4,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input logic                 clk,
    input logic                 reset,
    bpred_update_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    logic [IDX_W-1:0] q_idx [DEPTH];
    logic [DEPTH-1:0] q_taken;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [SC_W-1:0]  starve_cnt;
    logic             flush_q;

    logic not_empty;
    logic full;
    logic upd_pri;
    logic upd_go;
    logic fetch_go;

    // Update priority and the port grant; reset blocks every grant.
    always_comb begin
        not_empty = (count != '0);
        full      = (count == CNT_W'(DEPTH));
        upd_pri   = not_empty &&
                    (!bus.fetch_req || full ||
                     starve_cnt == SC_W'(STARVE_MAX));
        upd_go    = upd_pri && !reset;
        fetch_go  = bus.fetch_req && !upd_pri && !reset;
    end

    // Table port mux and gated status outputs.
    always_comb begin
        bus.tbl_valid   = 1'b0;
        bus.tbl_we      = 1'b0;
        bus.tbl_idx     = '0;
        bus.tbl_taken   = 1'b0;
        unique case (1'b1)
            upd_go: begin
                bus.tbl_valid = 1'b1;
                bus.tbl_we    = 1'b1;
                bus.tbl_idx   = q_idx[rd_ptr];
                bus.tbl_taken = q_taken[rd_ptr];
            end
            fetch_go: begin
                bus.tbl_valid = 1'b1;
                bus.tbl_idx   = bus.fetch_idx;
            end
            default: ;
        endcase
        bus.fetch_stall = bus.fetch_req && upd_pri && !reset;
        bus.flush       = flush_q && !reset;
        bus.q_count     = reset ? '0 : count;
    end

    // Queue storage; contents need no reset since count gates them.
    always_ff @(posedge clk) begin
        if (bus.res_valid) begin
            q_idx[wr_ptr]   <= bus.res_idx;
            q_taken[wr_ptr] <= bus.res_taken;
        end
    end

    // Pointers, occupancy, starvation counter and flush register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            flush_q    <= 1'b0;
        end else begin
            flush_q <= bus.res_valid &&
                       (bus.res_taken ^ bus.res_pred_taken);
            if (bus.res_valid)
                wr_ptr <= wr_ptr + 1'b1;
            if (upd_go)
                rd_ptr <= rd_ptr + 1'b1;
            case ({bus.res_valid, upd_go})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (upd_go || !not_empty)
                starve_cnt <= '0;
            else if (fetch_go && starve_cnt != SC_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_bpred_update_arbiter.sv
// Directed bench for bpred_update_arbiter: a vector table for
// single-cycle behaviour plus sequences for queue corner cases.
module tb_bpred_update_arbiter;
    logic clk;
    logic reset;

    bpred_update_arbiter_if #(.IDX_W(4), .DEPTH(4)) bus ();

    bpred_update_arbiter #(
        .IDX_W(4), .DEPTH(4), .STARVE_MAX(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int rst; int freq; int fidx;
        int rv; int ridx; int rt; int rp;
        int ev; int ewe; int eidx; int etk;
        int est; int efl; int eq;
    } vec_t;

    vec_t vecs [17];
    int nchk;
    int nerr;
    int maxq;
    logic [4:0] writes [$];
    logic [4:0] exp_w [$];

    // Record every table write as {taken, idx} and peak occupancy.
    always @(negedge clk) begin
        if (bus.tbl_valid && bus.tbl_we)
            writes.push_back({bus.tbl_taken, bus.tbl_idx});
        if (int'(bus.q_count) > maxq)
            maxq = int'(bus.q_count);
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fetch_req      = 1'b0;
        bus.fetch_idx      = '0;
        bus.res_valid      = 1'b0;
        bus.res_idx        = '0;
        bus.res_taken      = 1'b0;
        bus.res_pred_taken = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input int idx, input int tk, input int pr);
        bus.res_valid      = 1'b1;
        bus.res_idx        = 4'(idx);
        bus.res_taken      = 1'(tk);
        bus.res_pred_taken = 1'(pr);
    endtask

    initial begin
        int full_exp [5];
        nchk  = 0;
        nerr  = 0;
        maxq  = 0;
        reset = 1'b1;
        idle_inputs();

        vecs[0]  = '{1,0,0,  0,0,0,0,   0,0,0,0,  0,0,0};
        vecs[1]  = '{1,0,0,  0,0,0,0,   0,0,0,0,  0,0,0};
        vecs[2]  = '{0,0,0,  0,0,0,0,   0,0,0,0,  0,0,0};
        vecs[3]  = '{0,0,0,  1,5,1,1,   0,0,0,0,  0,0,0};
        vecs[4]  = '{0,0,0,  0,0,0,0,   1,1,5,1,  0,0,1};
        vecs[5]  = '{0,0,0,  0,0,0,0,   0,0,0,0,  0,0,0};
        vecs[6]  = '{0,0,0,  1,9,0,1,   0,0,0,0,  0,0,0};
        vecs[7]  = '{0,0,0,  0,0,0,0,   1,1,9,0,  0,1,1};
        vecs[8]  = '{0,0,0,  0,0,0,0,   0,0,0,0,  0,0,0};
        vecs[9]  = '{0,1,3,  0,0,0,0,   1,0,3,0,  0,0,0};
        vecs[10] = '{0,1,7,  1,12,1,0,  1,0,7,0,  0,0,0};
        vecs[11] = '{0,1,8,  0,0,0,0,   1,0,8,0,  0,1,1};
        vecs[12] = '{0,1,10, 0,0,0,0,   1,0,10,0, 0,0,1};
        vecs[13] = '{0,1,11, 0,0,0,0,   1,0,11,0, 0,0,1};
        vecs[14] = '{0,1,13, 0,0,0,0,   1,1,12,1, 1,0,1};
        vecs[15] = '{0,1,14, 0,0,0,0,   1,0,14,0, 0,0,0};
        vecs[16] = '{0,0,0,  0,0,0,0,   0,0,0,0,  0,0,0};

        for (int i = 0; i < 17; i++) begin
            tick();
            reset              = 1'(vecs[i].rst);
            bus.fetch_req      = 1'(vecs[i].freq);
            bus.fetch_idx      = 4'(vecs[i].fidx);
            bus.res_valid      = 1'(vecs[i].rv);
            bus.res_idx        = 4'(vecs[i].ridx);
            bus.res_taken      = 1'(vecs[i].rt);
            bus.res_pred_taken = 1'(vecs[i].rp);
            #3;
            chk($sformatf("v%0d_valid", i), int'(bus.tbl_valid), vecs[i].ev);
            chk($sformatf("v%0d_we", i), int'(bus.tbl_we), vecs[i].ewe);
            chk($sformatf("v%0d_idx", i), int'(bus.tbl_idx), vecs[i].eidx);
            chk($sformatf("v%0d_taken", i), int'(bus.tbl_taken), vecs[i].etk);
            chk($sformatf("v%0d_stall", i), int'(bus.fetch_stall), vecs[i].est);
            chk($sformatf("v%0d_flush", i), int'(bus.flush), vecs[i].efl);
            chk($sformatf("v%0d_qcnt", i), int'(bus.q_count), vecs[i].eq);
        end

        // Full queue with fetch held: forced updates in push order.
        do_reset();
        writes.delete();
        maxq = 0;
        full_exp = '{1, 2, 3, 4, 6};
        bus.fetch_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            push(full_exp[i], 1, 1);
            if (i == 4) begin
                #3;
                chk("full_stall0", int'(bus.fetch_stall), 1);
                chk("full_q0", int'(bus.q_count), 4);
                chk("full_idx0", int'(bus.tbl_idx), 1);
            end
        end
        tick();
        bus.res_valid = 1'b0;
        #3;
        chk("full_stall1", int'(bus.fetch_stall), 1);
        chk("full_q1", int'(bus.q_count), 4);
        chk("full_idx1", int'(bus.tbl_idx), 2);
        for (int k = 0; k < 40 && writes.size() < 5; k++)
            tick();
        chk("full_nwr", writes.size(), 5);
        for (int j = 0; j < 5 && j < writes.size(); j++)
            chk($sformatf("full_ord%0d", j), int'(writes[j][3:0]), full_exp[j]);
        chk("full_maxq_le4", int'(maxq <= 4), 1);
        tick();
        bus.fetch_req = 1'b0;
        #3;
        chk("full_drained", int'(bus.q_count), 0);

        // Ten entries across pointer wrap with mixed fetch traffic.
        writes.delete();
        exp_w.delete();
        maxq = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.fetch_req = (i % 3 != 2);
            bus.fetch_idx = 4'(i);
            if (i % 2 == 0) begin
                int j;
                j = i / 2;
                push((j * 7 + 3) % 16, j % 2, j % 2);
                exp_w.push_back({1'(j % 2), 4'((j * 7 + 3) % 16)});
            end else begin
                bus.res_valid = 1'b0;
            end
        end
        tick();
        bus.res_valid = 1'b0;
        bus.fetch_req = 1'b1;
        for (int k = 0; k < 60 && writes.size() < 10; k++)
            tick();
        chk("wrap_nwr", writes.size(), 10);
        for (int j = 0; j < 10 && j < writes.size(); j++)
            chk($sformatf("wrap_ord%0d", j), int'(writes[j]), int'(exp_w[j]));
        chk("wrap_maxq_le4", int'(maxq <= 4), 1);

        // Reset with three entries pending: all of them are dropped.
        tick();
        bus.fetch_req = 1'b0;
        for (int k = 0; k < 10 && bus.q_count != 0; k++)
            tick();
        bus.fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            push(i + 1, 1, 1);
        end
        tick();
        bus.res_valid = 1'b0;
        reset = 1'b1;
        writes.delete();
        #3;
        chk("rst_q", int'(bus.q_count), 0);
        chk("rst_valid", int'(bus.tbl_valid), 0);
        chk("rst_stall", int'(bus.fetch_stall), 0);
        tick();
        reset = 1'b0;
        bus.fetch_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #3;
            chk($sformatf("rst_after_q%0d", i), int'(bus.q_count), 0);
            chk($sformatf("rst_after_v%0d", i), int'(bus.tbl_valid), 0);
            tick();
        end
        chk("rst_no_writes", writes.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/bpred_update_arbiter.md
# bpred_update_arbiter

Arbiter and sequencer for the single-ported two-bit branch predictor table. It buffers branch outcomes resolved in the execute stage in an in-order queue and shares the table port between fetch-stage lookups and queued counter updates. It also raises the one-cycle pipeline flush on a misprediction. It sits between the fetch stage, the execute stage and the predictor table.

## Interface
Parameters:
- IDX_W, 4, predictor table index width
- DEPTH, 4, update queue depth; power of two, ≥2
- STARVE_MAX, 3, consecutive fetch grants tolerated while the queue is non-empty

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- fetch_req  in  1  fetch requests a table lookup this cycle
- fetch_idx  in  IDX_W  lookup index
- res_valid  in  1  execute resolved a branch this cycle; cannot be back-pressured
- res_idx  in  IDX_W  index of the resolved branch
- res_taken  in  1  actual outcome
- res_pred_taken  in  1  prediction used for that branch
- tbl_valid  out  1  table port active this cycle
- tbl_we  out  1  1 = counter update, 0 = lookup
- tbl_idx  out  IDX_W  table index
- tbl_taken  out  1  outcome for the update; 0 on lookups
- fetch_stall  out  1  fetch_req present but the port is given to an update
- flush  out  1  registered one-cycle misprediction flush
- q_count  out  log2(DEPTH)+1  queue occupancy

## Operation
- The queue is a circular FIFO of {idx, taken} with wr_ptr, rd_ptr and count.
- Push: res_valid=1 at a clock edge writes {res_idx, res_taken} at wr_ptr.
- Pop: occurs on an edge where the update is granted.
- Push and pop on the same edge: count unchanged. Both pointers wrap modulo DEPTH.
- Update priority (upd_pri), combinational; true when count≠0 and any of:
  - fetch_req=0
  - count==DEPTH
  - starve_cnt==STARVE_MAX
- Port outputs:
  - upd_pri: tbl_valid=1, tbl_we=1, tbl_idx=head idx, tbl_taken=head taken, pop this edge.
  - Else if fetch_req: tbl_valid=1, tbl_we=0, tbl_idx=fetch_idx, tbl_taken=0.
  - Else: tbl_valid=0, tbl_we=0, tbl_idx=0, tbl_taken=0.
- fetch_stall = fetch_req & upd_pri.
- starve_cnt update, evaluated in this priority order:
  - Cleared to 0 on an update grant or when count==0.
  - Otherwise incremented, saturating at STARVE_MAX, on a fetch grant.
- Overflow is impossible. When full, the update is forced, so a simultaneous push and pop keeps count==DEPTH.
- flush: registered as res_valid & (res_taken ^ res_pred_taken). Flush does not clear the queue; resolved outcomes are always committed.
- Updates reach the table in resolution order. There is no bypass from res_* to the table port.
- All outputs are driven during reset, with these values:
  - tbl_valid=0, fetch_stall=0, flush=0, q_count=0.
  - starve_cnt, count and both pointers 0.
  - Queue contents are discarded.
  - Gate tbl_valid and fetch_stall with ~reset.

## Timing
- res_valid in cycle N: entry is visible at the head in N+1, when the earliest tbl_we=1 occurs. flush=1 in exactly cycle N+1.
- Lookup latency: tbl_* follow fetch_req/fetch_idx combinationally in the same cycle when not stalled.
- Worst-case fetch starvation wait: STARVE_MAX cycles before one forced update. After that update, fetch regains priority unless the queue is full.
- A full queue with fetch_req held high gives one update per cycle until count<DEPTH. Fetch is stalled throughout.
- Reset asserted mid-operation takes effect at the next edge. Pending entries are lost and no table write occurs in the reset cycle.

## Test plan
- Idle update: reset, then fetch_req=0, res_valid pulse with idx=5, taken=1, pred=1. Required: cycle N+1 tbl_we=1, tbl_idx=5, tbl_taken=1, flush=0. Cycle N+2 q_count=0.
- Mispredict: res_valid with taken=0, pred=1. Required: flush=1 for exactly one cycle at N+1, and the entry is still written to the table.
- Starvation: fetch_req held 1, one entry queued. Required:
  - 3 fetch grants, then one cycle with fetch_stall=1 and tbl_we=1.
  - Then fetch grants resume with starve_cnt=0.
- Full queue: fetch_req=1, four res_valid pulses in consecutive cycles (idx 1,2,3,4), then a fifth (idx 6) while full. Required:
  - Forced updates in order 1,2,3,4,6.
  - No entry lost; q_count never exceeds 4.
- Wrap-around: push and pop 10 entries with interleaved fetch traffic. Required: table writes occur in exact push order across pointer wrap.
- Reset mid-operation: 3 entries queued, reset for 1 cycle. Required: q_count=0 and tbl_valid=0 during reset, and no write of the stale entries afterwards.
